// File: rtl/add3_inverse_serial_if.sv
// Request/response bundle for add3_inverse_serial: a request carries the forward
// result and known operand, and the response returns the recovered operand.
interface add3_inverse_serial_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH:0]   in_sum;
  logic [WIDTH-1:0] in_opnd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_opnd;
  logic             out_err;

  modport master (
    output in_valid, in_mode, in_sum, in_opnd, out_ready,
    input  in_ready, out_valid, out_opnd, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_sum, in_opnd, out_ready,
    output in_ready, out_valid, out_opnd, out_err
  );
endinterface

// File: rtl/add3_inverse_serial.sv
// Recovers the unknown operand from a forward add result, one borrow stage per cycle
// (LSB first), or bypasses the result. Optional saturation: define ADD3_INV_SAT_EN.
module add3_inverse_serial #(
  parameter int WIDTH = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  add3_inverse_serial_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] opnd_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] final_opnd;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             borrow;
  logic             borrow_next;
  logic             bit_d;
  logic             last_bit;
  logic             sel;
  logic             accept;
  logic             in_ready_c;
  logic             out_valid_c;
  logic [WIDTH-1:0] out_opnd_q;
  logic             out_err_q;

  assign sel         = bus.in_mode[0] ~^ bus.in_mode[1];
  assign accept      = bus.in_valid & in_ready_c;
  assign bit_d       = sum_sh[0] ^ opnd_sh[0] ^ borrow;
  assign borrow_next = (~sum_sh[0] & opnd_sh[0]) | (~(sum_sh[0] ^ opnd_sh[0]) & borrow);
  assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
  assign diff_next   = (diff_sh >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));

`ifdef ADD3_INV_SAT_EN
  // A borrow out of the top stage means the known operand exceeded the result word
  assign final_opnd = borrow_next ? '0 : diff_next;
`else
  assign final_opnd = diff_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = sel ? DONE : SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE:    in_ready_c  = rst_n;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sh     <= '0;
      opnd_sh    <= '0;
      diff_sh    <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      borrow     <= 1'b0;
      out_opnd_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (sel) begin
              out_opnd_q <= bus.in_sum[WIDTH-1:0];
              out_err_q  <= bus.in_sum[WIDTH];
            end else begin
              sum_sh  <= bus.in_sum[WIDTH-1:0];
              opnd_sh <= bus.in_opnd;
              carry   <= bus.in_sum[WIDTH];
              diff_sh <= '0;
              borrow  <= 1'b0;
              cnt     <= '0;
            end
          end
        end
        SHIFT: begin
          sum_sh  <= sum_sh >> 1;
          opnd_sh <= opnd_sh >> 1;
          diff_sh <= diff_next;
          borrow  <= borrow_next;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            out_opnd_q <= final_opnd;
            out_err_q  <= borrow_next ^ carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_opnd  = out_opnd_q;
  assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_add3_inverse_serial.sv
// Self-checking bench for add3_inverse_serial: directed cases, backpressure, reset abort,
// back-to-back requests and random requests against an arithmetic reference model.
module tb_add3_inverse_serial;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add3_inverse_serial_if #(.WIDTH(W)) bus ();

  add3_inverse_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain modular subtraction; borrow out means the operand exceeded the low word
  function automatic void model(input int mode, input int sum, input int opnd,
                                output int eo, output int ee, output int el);
    int s;
    int c;
    s = sum % (1 << W);
    c = sum >> W;
    if ((mode & 1) == ((mode >> 1) & 1)) begin
      eo = s;
      ee = c;
      el = 1;
    end else begin
      eo = (s - opnd + (1 << W)) % (1 << W);
      ee = ((opnd > s) ? 1 : 0) ^ c;
      el = W + 1;
`ifdef ADD3_INV_SAT_EN
      if (opnd > s) eo = 0;
`endif
    end
  endfunction

  task automatic applyStimulus(input string tag, input int mode, input int sum, input int opnd,
                               output int lat);
    @(negedge clk);
    compare({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'(mode);
    bus.in_sum   = 4'(sum);
    bus.in_opnd  = 3'(opnd);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_mode  = 2'($urandom_range(0, 3));
    bus.in_sum   = 4'($urandom_range(0, 15));
    bus.in_opnd  = 3'($urandom_range(0, 7));
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input int mode, input int sum, input int opnd,
                             input int hold);
    int lat;
    int eo;
    int ee;
    int el;
    logic [W-1:0] held_o;
    logic held_e;
    model(mode, sum, opnd, eo, ee, el);
    applyStimulus(tag, mode, sum, opnd, lat);
    compare({tag, "_latency"}, 32'(lat), 32'(el));
    compare({tag, "_opnd"}, 32'(bus.out_opnd), 32'(eo));
    compare({tag, "_err"}, 32'(bus.out_err), 32'(ee));
    held_o = bus.out_opnd;
    held_e = bus.out_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      compare({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      compare({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
      compare({tag, "_hold_opnd"}, 32'(bus.out_opnd), 32'(held_o));
      compare({tag, "_hold_err"}, 32'(bus.out_err), 32'(held_e));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    compare({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    compare({tag, "_ready_rise"}, 32'(bus.in_ready), 32'd1);
    compare({tag, "_opnd_kept"}, 32'(bus.out_opnd), 32'(held_o));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int hs;
    int acc_cyc[2];
    int hs_cyc[2];
    int res_o[2];
    int res_e[2];
    int eo;
    int ee;
    int el;

    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'b00;
    bus.in_sum    = '0;
    bus.in_opnd   = '0;
    bus.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    compare("reset_in_ready", 32'(bus.in_ready), 32'd0);
    compare("reset_out_valid", 32'(bus.out_valid), 32'd0);
    compare("reset_out_opnd", 32'(bus.out_opnd), 32'd0);
    compare("reset_out_err", 32'(bus.out_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare("release_in_ready", 32'(bus.in_ready), 32'd1);

    checkOutput("rec_a", 1, 4'b1010, 3, 0);
    checkOutput("rec_b", 1, 4'b0111, 3, 0);
    checkOutput("rec_borrow", 2, 4'b0010, 5, 0);
    checkOutput("byp_a", 3, 4'b1101, 0, 0);
    checkOutput("byp_b", 0, 4'b0110, 2, 0);
    checkOutput("backpressure", 1, 4'b1011, 6, 5);

    // Abort during the second SHIFT cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'b01;
    bus.in_sum   = 4'b0111;
    bus.in_opnd  = 3'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("abort_out_valid", 32'(bus.out_valid), 32'd0);
    compare("abort_out_opnd", 32'(bus.out_opnd), 32'd0);
    compare("abort_out_err", 32'(bus.out_err), 32'd0);
    compare("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare("abort_release_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("after_abort", 1, 4'b0101, 2, 0);

    // Back-to-back recover requests with in_valid held high
    @(negedge clk);
    acc = 0;
    hs = 0;
    acc_cyc = '{-1, -1};
    hs_cyc = '{-1, -1};
    res_o = '{-1, -1};
    res_e = '{-1, -1};
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b01;
    bus.in_sum    = 4'b0111;
    bus.in_opnd   = 3'd3;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.in_valid && bus.in_ready) begin
        if (acc < 2) acc_cyc[acc] = c;
        acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (hs < 2) begin
          hs_cyc[hs] = c;
          res_o[hs] = int'(bus.out_opnd);
          res_e[hs] = int'(bus.out_err);
        end
        hs++;
      end
      @(negedge clk);
      if (acc == 1) begin
        bus.in_mode = 2'b10;
        bus.in_sum  = 4'b0110;
        bus.in_opnd = 3'd1;
      end
      if (acc >= 2) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    compare("b2b_accepts", 32'(acc), 32'd2);
    compare("b2b_handshakes", 32'(hs), 32'd2);
    compare("b2b_gap", 32'(acc_cyc[1]), 32'(hs_cyc[0] + 1));
    compare("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
    model(1, 4'b0111, 3, eo, ee, el);
    compare("b2b_first_opnd", 32'(res_o[0]), 32'(eo));
    compare("b2b_first_err", 32'(res_e[0]), 32'(ee));
    model(2, 4'b0110, 1, eo, ee, el);
    compare("b2b_second_opnd", 32'(res_o[1]), 32'(eo));
    compare("b2b_second_err", 32'(res_e[1]), 32'(ee));

    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("rand%0d", i), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
